// File: rtl/rv32i_types.sv
// Shared types for the fetch / instruction-queue slice of the RV32I front end.
package rv32i_types;

    localparam int          IQ_SIZE       = 8;
    localparam int          IQ_INDEX_BITS = 3;
    localparam logic [31:0] RESET_PC      = 32'h6000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_iq_fifo.sv
// Circular buffer of {pc, instr} entries. clear beats enq/deq; enq is dropped when full.
module iq_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enq,
    input  iq_entry_t        enq_data,
    input  logic             deq,
    output iq_entry_t        head_data,
    output logic             empty,
    output logic             full,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    iq_entry_t          r_mem [DEPTH];
    logic [IDX_W-1:0]   r_head;
    logic [IDX_W-1:0]   r_tail;
    logic [IDX_W:0]     r_count;
    logic               w_do_enq;
    logic               w_do_deq;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign head_data = r_mem[r_head];
    assign w_do_enq  = enq && !full;
    assign w_do_deq  = deq && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_deq) r_head <= r_head + 1'b1;
            if (w_do_enq) r_tail <= r_tail + 1'b1;
            r_count <= r_count + {{IDX_W{1'b0}}, w_do_enq} - {{IDX_W{1'b0}}, w_do_deq};
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_enq && !clear) r_mem[r_tail] <= enq_data;
    end

endmodule

// File: rtl/fetch_iq.sv
// Fetch FSM (one outstanding I-cache read) feeding an in-order instruction queue.
module fetch_iq
    import rv32i_types::*;
#(
    parameter int          iq_size       = IQ_SIZE,
    parameter int          iq_index_bits = IQ_INDEX_BITS,
    parameter logic [31:0] reset_pc      = RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_read,
    output logic [31:0]              imem_address,
    input  logic                     imem_resp,
    input  logic [31:0]              imem_rdata,
    input  logic                     flush,
    input  logic [31:0]              pc_brrs,
    input  logic                     halt,
    input  logic                     dequeue,
    output logic [31:0]              iq_instr,
    output logic [31:0]              PC_iq_head,
    output logic                     iq_empty,
    output logic                     iq_full,
    output logic [iq_index_bits:0]   iq_count
);

    localparam logic [iq_index_bits:0] LAST_CNT = (iq_index_bits + 1)'(iq_size - 1);

    fetch_state_t   r_state;
    fetch_state_t   w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    w_fetch_pc_nxt;
    logic [31:0]    r_drop_pc;
    logic [31:0]    w_drop_pc_nxt;
    logic           w_enq;
    logic           w_full_after;
    iq_entry_t      w_enq_data;
    iq_entry_t      w_head;

    assign w_enq_data = '{pc: r_fetch_pc, instr: imem_rdata};
    assign iq_instr   = w_head.instr;
    assign PC_iq_head = w_head.pc;

    // Queue is full after this edge only if we fill the last slot without a matching dequeue.
    assign w_full_after = (iq_count == LAST_CNT) && !(dequeue && !iq_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= reset_pc;
            r_drop_pc  <= reset_pc;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop_pc  <= w_drop_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_pc_nxt  = r_drop_pc;
        w_enq          = 1'b0;
        imem_read      = 1'b0;
        imem_address   = r_fetch_pc;
        unique case (r_state)
            IDLE: begin
                if (flush)                    w_fetch_pc_nxt = pc_brrs;
                else if (!iq_full && !halt)   w_state_nxt    = REQ;
            end
            REQ: begin
                imem_read = 1'b1;
                if (imem_resp && !flush) begin
                    w_enq          = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = (w_full_after || halt) ? IDLE : REQ;
                end else if (imem_resp) begin
                    w_fetch_pc_nxt = pc_brrs;
                    w_state_nxt    = halt ? IDLE : REQ;
                end else if (flush) begin
                    // Cache needs the address held until it answers, so park the stale PC.
                    w_fetch_pc_nxt = pc_brrs;
                    w_drop_pc_nxt  = r_fetch_pc;
                    w_state_nxt    = DROP;
                end
            end
            DROP: begin
                imem_read    = 1'b1;
                imem_address = r_drop_pc;
                if (flush)     w_fetch_pc_nxt = pc_brrs;
                if (imem_resp) w_state_nxt    = halt ? IDLE : REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    iq_fifo #(
        .DEPTH (iq_size),
        .IDX_W (iq_index_bits)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .enq       (w_enq),
        .enq_data  (w_enq_data),
        .deq       (dequeue),
        .head_data (w_head),
        .empty     (iq_empty),
        .full      (iq_full),
        .count     (iq_count)
    );

endmodule

// File: tb/tb_fetch_iq.sv
// Directed bench for fetch_iq: fill, refill, flush variants, halt, wrap, async reset.
module tb_fetch_iq;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] pc_brrs;
    logic        halt;
    logic        dequeue;
    logic [31:0] iq_instr;
    logic [31:0] PC_iq_head;
    logic        iq_empty;
    logic        iq_full;
    logic [3:0]  iq_count;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_iq dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .pc_brrs      (pc_brrs),
        .halt         (halt),
        .dequeue      (dequeue),
        .iq_instr     (iq_instr),
        .PC_iq_head   (PC_iq_head),
        .iq_empty     (iq_empty),
        .iq_full      (iq_full),
        .iq_count     (iq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One idle request cycle, then a one-cycle response carrying pc^K.
    task automatic respond(input logic [31:0] pc);
        chk("req_read", imem_read, 1);
        chk("req_addr", imem_address, pc);
        tick();
        imem_resp  = 1'b1;
        imem_rdata = pc ^ K;
        tick();
        imem_resp  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; flush = 1'b0;
        pc_brrs = '0; halt = 1'b0; dequeue = 1'b0;
        repeat (2) tick();
        chk("rst_read",  imem_read, 0);
        chk("rst_empty", iq_empty, 1);
        chk("rst_full",  iq_full, 0);
        chk("rst_count", iq_count, 0);
        chk("rst_addr",  imem_address, 32'h6000_0000);

        // Fill the queue without dequeuing
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) respond(32'h6000_0000 + 32'(4 * i));
        chk("fill_full",  iq_full, 1);
        chk("fill_count", iq_count, 8);
        chk("fill_read",  imem_read, 0);
        chk("fill_head",  PC_iq_head, 32'h6000_0000);
        chk("fill_instr", iq_instr, 32'h6000_0000 ^ K);

        // One dequeue from full, fetch resumes at 0x20
        dequeue = 1'b1; tick(); dequeue = 1'b0;
        chk("deq_count", iq_count, 7);
        chk("deq_head",  PC_iq_head, 32'h6000_0004);
        tick();
        respond(32'h6000_0020);
        chk("refill_count", iq_count, 8);
        chk("refill_full",  iq_full, 1);

        // Flush while request outstanding, no response that cycle -> DROP
        dequeue = 1'b1; tick(); dequeue = 1'b0;
        tick();
        chk("pre_flush_addr", imem_address, 32'h6000_0024);
        flush = 1'b1; pc_brrs = 32'h6000_0100;
        tick();
        flush = 1'b0;
        chk("drop_empty", iq_empty, 1);
        chk("drop_read",  imem_read, 1);
        chk("drop_addr",  imem_address, 32'h6000_0024);
        imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_resp = 1'b0;
        chk("drop_discard", iq_count, 0);
        respond(32'h6000_0100);
        chk("redir_count", iq_count, 1);
        chk("redir_head",  PC_iq_head, 32'h6000_0100);
        chk("redir_instr", iq_instr, 32'h6000_0100 ^ K);

        // Flush coinciding with a response: data dropped, no DROP cycle
        chk("pre_f2_addr", imem_address, 32'h6000_0104);
        flush = 1'b1; pc_brrs = 32'h6000_0200; imem_resp = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        flush = 1'b0; imem_resp = 1'b0;
        chk("f2_empty", iq_empty, 1);
        chk("f2_read",  imem_read, 1);
        chk("f2_addr",  imem_address, 32'h6000_0200);
        respond(32'h6000_0200);
        chk("f2_count", iq_count, 1);
        chk("f2_head",  PC_iq_head, 32'h6000_0200);

        // Halt mid-request: in-flight read completes, then no more requests
        halt = 1'b1;
        tick();
        chk("halt_inflight", imem_read, 1);
        chk("halt_addr", imem_address, 32'h6000_0204);
        imem_resp = 1'b1; imem_rdata = 32'h6000_0204 ^ K;
        tick();
        imem_resp = 1'b0;
        chk("halt_count", iq_count, 2);
        chk("halt_read0", imem_read, 0);
        chk("halt_head0", PC_iq_head, 32'h6000_0200);
        dequeue = 1'b1;
        tick();
        chk("halt_read1", imem_read, 0);
        chk("halt_head1", PC_iq_head, 32'h6000_0204);
        chk("halt_instr1", iq_instr, 32'h6000_0204 ^ K);
        tick();
        chk("halt_empty", iq_empty, 1);
        tick();
        chk("deq_empty_ign", iq_count, 0);
        chk("halt_read2", imem_read, 0);
        dequeue = 1'b0;

        // Flush in IDLE to 0x300, then fill 7 and drain 4 -> head idx 4, tail idx 7
        halt = 1'b0; flush = 1'b1; pc_brrs = 32'h6000_0300;
        tick();
        flush = 1'b0;
        chk("idle_flush_read", imem_read, 0);
        tick();
        for (int i = 0; i < 7; i++) respond(32'h6000_0300 + 32'(4 * i));
        dequeue = 1'b1;
        repeat (4) tick();
        dequeue = 1'b0;
        chk("wrap_pre_count", iq_count, 3);
        chk("wrap_pre_head",  PC_iq_head, 32'h6000_0310);
        chk("wrap_pre_addr",  imem_address, 32'h6000_031C);
        dequeue = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h6000_031C ^ K;
        tick();
        chk("wrap_cnt1",  iq_count, 3);
        chk("wrap_head1", PC_iq_head, 32'h6000_0314);
        chk("wrap_addr1", imem_address, 32'h6000_0320);
        imem_rdata = 32'h6000_0320 ^ K;
        tick();
        dequeue = 1'b0; imem_resp = 1'b0;
        chk("wrap_cnt2",  iq_count, 3);
        chk("wrap_head2", PC_iq_head, 32'h6000_0318);
        dequeue = 1'b1;
        tick();
        chk("wrap_head3",  PC_iq_head, 32'h6000_031C);
        chk("wrap_instr3", iq_instr, 32'h6000_031C ^ K);
        tick();
        chk("wrap_head4",  PC_iq_head, 32'h6000_0320);
        chk("wrap_instr4", iq_instr, 32'h6000_0320 ^ K);
        tick();
        dequeue = 1'b0;
        chk("wrap_empty", iq_empty, 1);

        // Asynchronous reset mid-request; a pending response must be ignored
        #2;
        rst = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("arst_read",  imem_read, 0);
        chk("arst_addr",  imem_address, 32'h6000_0000);
        chk("arst_empty", iq_empty, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        imem_resp = 1'b0;
        chk("arst_count", iq_count, 0);
        chk("arst_read2", imem_read, 1);
        chk("arst_addr2", imem_address, 32'h6000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
